// File: rtl/opll_bus_pkg.sv
// Shared types and constants for the OPLL host-write sequencer.
// Contents:
//   opll_state_e - bus sequencer FSM states
//   A0_ADDR/A0_DATA - YM2413 A0 encoding for address and data phases
//   DEF_ADDR_WAIT/DEF_DATA_WAIT - default post-strobe wait times in clk cycles
//   opll_write_t - packed register/data payload; the top prepends the chip index
//   cnt_width() - width of the shared phase counter
package opll_bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddrStb,
        StAddrGap,
        StDataStb,
        StDataGap
    } opll_state_e;

    localparam logic A0_ADDR = 1'b0;
    localparam logic A0_DATA = 1'b1;

    localparam int unsigned DEF_ADDR_WAIT = 12;
    localparam int unsigned DEF_DATA_WAIT = 84;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } opll_write_t;

    // Largest terminal count is max(a,b,c)-1, so clog2 of the max is enough.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/opll_sync_fifo.sv
// Synchronous FIFO with flush and occupancy output.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   i_push, i_wdata    - write request and data (ignored when full or flushing)
//   i_pop              - read request (ignored when empty or flushing)
//   i_flush            - drop all stored entries, reset pointers
//   o_rdata            - head entry (valid when !o_empty)
//   o_full, o_empty    - status
//   o_level            - occupancy, 0..DEPTH
module opll_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic                    i_flush,
    input  logic [WIDTH-1:0]        i_wdata,
    output logic [WIDTH-1:0]        o_rdata,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    // Full blocks a push even if a pop frees a slot in the same cycle.
    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/opll_bus_write_sequencer.sv
// Queued host-write front end for one or more YM2413-compatible cores.
// Host (chip, reg, data) triples are buffered and replayed as address/data
// strobe pairs with fixed strobe width and post-strobe waits.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   i_valid/o_ready           - push handshake; o_ready = FIFO not full
//   i_chip, i_reg, i_data     - write triple
//   i_flush                   - drop queued (not in-flight) entries
//   o_cs_n, o_wr_n, o_a0, o_d - registered OPLL bus
//   o_level                   - FIFO occupancy
//   o_busy                    - FSM active or entries queued
module opll_bus_write_sequencer
    import opll_bus_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned NUM_CHIPS  = 1,
    parameter int unsigned CHIP_W     = 1,
    parameter int unsigned WR_PULSE   = 2,
    parameter int unsigned ADDR_WAIT  = DEF_ADDR_WAIT,
    parameter int unsigned DATA_WAIT  = DEF_DATA_WAIT,
    parameter int unsigned ADDR_CACHE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [CHIP_W-1:0]       i_chip,
    input  logic [7:0]              i_reg,
    input  logic [7:0]              i_data,
    input  logic                    i_flush,
    output logic [NUM_CHIPS-1:0]    o_cs_n,
    output logic                    o_wr_n,
    output logic                    o_a0,
    output logic [7:0]              o_d,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_busy
);

    localparam int unsigned EW = CHIP_W + 16;
    localparam int unsigned CW = cnt_width(WR_PULSE, ADDR_WAIT, DATA_WAIT);

    localparam logic [CW-1:0] L_PULSE_LAST = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0] L_AGAP_LAST  = CW'((ADDR_WAIT > 0) ? ADDR_WAIT - 1 : 0);
    // The IDLE pop cycle supplies the final data-gap cycle.
    localparam logic [CW-1:0] L_DGAP_LAST  = CW'((DATA_WAIT > 1) ? DATA_WAIT - 2 : 0);

    logic [EW-1:0]          w_head;
    logic [CHIP_W-1:0]      w_head_chip;
    opll_write_t            w_head_pl;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [$clog2(DEPTH):0] w_level;
    logic                   w_pop;
    logic                   w_hit;

    opll_state_e            r_state, w_state_d;
    logic [CW-1:0]          r_cnt, w_cnt_d;
    logic [CHIP_W-1:0]      r_chip;
    opll_write_t            r_pl;
    logic [NUM_CHIPS-1:0]   r_cache_vld;
    logic [7:0]             r_cache_reg [NUM_CHIPS];

    logic [NUM_CHIPS-1:0]   w_sel_n;
    logic [NUM_CHIPS-1:0]   w_cs_n, r_cs_n;
    logic                   w_wr_n, r_wr_n;
    logic                   w_a0, r_a0;
    logic [7:0]             w_d, r_d;

    opll_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_valid),
        .i_pop   (w_pop),
        .i_flush (i_flush),
        .i_wdata ({i_chip, i_reg, i_data}),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_level)
    );

    assign w_head_chip = w_head[EW-1:16];
    assign w_head_pl   = w_head[15:0];

    assign o_ready = !w_fifo_full;
    assign o_level = w_level;
    assign o_busy  = (r_state != StIdle) || (w_level != '0);
    assign o_cs_n  = r_cs_n;
    assign o_wr_n  = r_wr_n;
    assign o_a0    = r_a0;
    assign o_d     = r_d;

    // Out-of-range chip indices never match, so they always miss.
    always_comb begin
        w_hit = 1'b0;
        for (int c = 0; c < NUM_CHIPS; c++) begin
            if ((ADDR_CACHE != 0) && (w_head_chip == CHIP_W'(c)) && r_cache_vld[c] &&
                (r_cache_reg[c] == w_head_pl.reg_addr)) begin
                w_hit = 1'b1;
            end
        end
    end

    // State register with phase counter and in-flight entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_chip  <= '0;
            r_pl    <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_pop) begin
                r_chip <= w_head_chip;
                r_pl   <= w_head_pl;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_pop     = 1'b0;
        case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (!w_fifo_empty && !i_flush) begin
                    w_pop     = 1'b1;
                    w_state_d = w_hit ? StDataStb : StAddrStb;
                end
            end
            StAddrStb: begin
                if (r_cnt == L_PULSE_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = (ADDR_WAIT == 0) ? StDataStb : StAddrGap;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            StAddrGap: begin
                if (r_cnt == L_AGAP_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = StDataStb;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            StDataStb: begin
                if (r_cnt == L_PULSE_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = (DATA_WAIT <= 1) ? StIdle : StDataGap;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            StDataGap: begin
                if (r_cnt == L_DGAP_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            default: begin
                w_cnt_d   = '0;
                w_state_d = StIdle;
            end
        endcase
    end

    // Address cache: remembers the last register address strobed per chip.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cache_vld <= '0;
        end else if (r_state == StAddrStb) begin
            for (int c = 0; c < NUM_CHIPS; c++) begin
                if (r_chip == CHIP_W'(c)) begin
                    r_cache_vld[c] <= 1'b1;
                    r_cache_reg[c] <= r_pl.reg_addr;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CHIPS; c++) begin
            w_sel_n[c] = (r_chip != CHIP_W'(c));
        end
    end

    // Output decode; A0/D hold their last strobe value while the bus is idle.
    always_comb begin
        w_cs_n = '1;
        w_wr_n = 1'b1;
        w_a0   = r_a0;
        w_d    = r_d;
        case (r_state)
            StAddrStb: begin
                w_cs_n = w_sel_n;
                w_wr_n = 1'b0;
                w_a0   = A0_ADDR;
                w_d    = r_pl.reg_addr;
            end
            StDataStb: begin
                w_cs_n = w_sel_n;
                w_wr_n = 1'b0;
                w_a0   = A0_DATA;
                w_d    = r_pl.data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_n <= '1;
            r_wr_n <= 1'b1;
            r_a0   <= A0_ADDR;
            r_d    <= '0;
        end else begin
            r_cs_n <= w_cs_n;
            r_wr_n <= w_wr_n;
            r_a0   <= w_a0;
            r_d    <= w_d;
        end
    end

endmodule

// File: tb/tb_opll_bus_write_sequencer.sv
// Bench for opll_bus_write_sequencer: a transaction-level model predicts the
// strobe timeline (each write as timed address/data strobes) and the FIFO
// occupancy; every cycle the bus, level, ready and busy are compared.
module tb_opll_bus_write_sequencer;

    localparam int DEPTH = 8;
    localparam int NCH   = 2;
    localparam int WP    = 2;
    localparam int AWT   = 12;
    localparam int DWT   = 84;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [1:0] chip = '0;
    logic [7:0] reg_a = '0;
    logic [7:0] data = '0;
    logic       flush = 1'b0;

    logic       ready, wr_n, a0, busy;
    logic [1:0] cs_n;
    logic [7:0] d;
    logic [3:0] level;
    logic       ready_nc, wr_n_nc, a0_nc, busy_nc;
    logic [1:0] cs_n_nc;
    logic [7:0] d_nc;
    logic [3:0] level_nc;

    opll_bus_write_sequencer #(
        .DEPTH(DEPTH), .NUM_CHIPS(NCH), .CHIP_W(2), .WR_PULSE(WP),
        .ADDR_WAIT(AWT), .DATA_WAIT(DWT), .ADDR_CACHE(1)
    ) u_dut (
        .clk(clk), .rst(rst), .i_valid(valid), .o_ready(ready), .i_chip(chip),
        .i_reg(reg_a), .i_data(data), .i_flush(flush), .o_cs_n(cs_n), .o_wr_n(wr_n),
        .o_a0(a0), .o_d(d), .o_level(level), .o_busy(busy)
    );

    opll_bus_write_sequencer #(
        .DEPTH(DEPTH), .NUM_CHIPS(NCH), .CHIP_W(2), .WR_PULSE(WP),
        .ADDR_WAIT(AWT), .DATA_WAIT(DWT), .ADDR_CACHE(0)
    ) u_dut_nc (
        .clk(clk), .rst(rst), .i_valid(valid), .o_ready(ready_nc), .i_chip(chip),
        .i_reg(reg_a), .i_data(data), .i_flush(flush), .o_cs_n(cs_n_nc), .o_wr_n(wr_n_nc),
        .o_a0(a0_nc), .o_d(d_nc), .o_level(level_nc), .o_busy(busy_nc)
    );

    always #5 clk = ~clk;

    typedef struct { int chip; int ra; int dv; } ent_t;
    typedef struct { int cs; int a0; int dv; int fall; } stb_t;

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];
    stb_t sq[$];
    int   cyc = 0;
    int   next_free = 0;
    bit   cv[4];
    int   cr[4];
    int   last_a0 = 0, last_d = 0;
    int   exp_wr, exp_cs, exp_a0, exp_d, exp_busy;
    int   n_addr = 0, n_data = 0, nc_addr = 0, nc_data = 0;
    logic prev_wr = 1'b1, prev_wr_nc = 1'b1;

    function automatic int cs_of(input int c);
        return (c < NCH) ? (3 & ~(1 << c)) : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance the model by one clock edge using the inputs driven for it.
    task automatic model_edge();
        int   old, f;
        ent_t e;
        bit   hit;
        if (rst) begin
            mq.delete();
            sq.delete();
            next_free = 0;
            last_a0 = 0;
            last_d = 0;
            foreach (cv[i]) cv[i] = 1'b0;
        end else begin
            old = mq.size();
            // A new write may start once the previous data strobe's wait has elapsed.
            if (old > 0 && cyc >= next_free - 1 && !flush) begin
                e = mq.pop_front();
                hit = (e.chip < NCH) && cv[e.chip] && (cr[e.chip] == e.ra);
                f = cyc + 1;
                if (!hit) begin
                    sq.push_back('{cs_of(e.chip), 0, e.ra, f});
                    if (e.chip < NCH) begin
                        cv[e.chip] = 1'b1;
                        cr[e.chip] = e.ra;
                    end
                    f += WP + AWT;
                end
                sq.push_back('{cs_of(e.chip), 1, e.dv, f});
                next_free = f + WP + DWT;
            end
            if (flush) mq.delete();
            else if (valid && old < DEPTH) mq.push_back('{int'(chip), int'(reg_a), int'(data)});
        end
        while (sq.size() > 0 && cyc >= sq[0].fall + WP) void'(sq.pop_front());
        if (sq.size() > 0 && sq[0].fall <= cyc) begin
            exp_wr = 0;
            exp_cs = sq[0].cs;
            exp_a0 = sq[0].a0;
            exp_d  = sq[0].dv;
            last_a0 = exp_a0;
            last_d  = exp_d;
        end else begin
            exp_wr = 1;
            exp_cs = 3;
            exp_a0 = last_a0;
            exp_d  = last_d;
        end
        exp_busy = (mq.size() > 0 || cyc < next_free - 2) ? 1 : 0;
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("level", level, mq.size());
        check("ready", ready, (mq.size() < DEPTH) ? 1 : 0);
        check("busy", busy, exp_busy);
        check("wr_n", wr_n, exp_wr);
        check("cs_n", cs_n, exp_cs);
        check("a0", a0, exp_a0);
        check("d", d, exp_d);
        if (prev_wr === 1'b1 && wr_n === 1'b0) begin
            if (a0) n_data++; else n_addr++;
        end
        if (prev_wr_nc === 1'b1 && wr_n_nc === 1'b0) begin
            if (a0_nc) nc_data++; else nc_addr++;
        end
        prev_wr = wr_n;
        prev_wr_nc = wr_n_nc;
    endtask

    task automatic push(input int c, input int r, input int v);
        valid = 1'b1;
        chip  = 2'(c);
        reg_a = 8'(r);
        data  = 8'(v);
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while ((busy || busy_nc) && k < max) begin
            tick();
            k++;
        end
        check("idle_timeout", (busy || busy_nc), 0);
    endtask

    task automatic wait_wr(input logic lvl, input logic need_a0, input logic use_a0);
        int k = 0;
        while (!(wr_n === lvl && (!use_a0 || a0 === need_a0)) && k < 300) begin
            tick();
            k++;
        end
        check("wait_wr_timeout", (wr_n === lvl) ? 1 : 0, 1);
    endtask

    int sa, sd, sna, snd;

    initial begin
        // Reset values
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single write: address strobe from E2, then data strobe, then idle
        push(0, 8'h10, 8'h55);
        tick();
        check("lat_e1_wr_n", wr_n, 1);
        tick();
        check("lat_e2_wr_n", wr_n, 0);
        check("lat_e2_d", d, 8'h10);
        wait_idle(400);

        // Cache: second write to same chip/register skips the address phase
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sa = n_addr; sd = n_data; sna = nc_addr; snd = nc_data;
        push(0, 8'h10, 8'h55);
        push(0, 8'h10, 8'hAA);
        wait_idle(600);
        check("cache_addr", n_addr - sa, 1);
        check("cache_data", n_data - sd, 2);
        check("nocache_addr", nc_addr - sna, 2);
        check("nocache_data", nc_data - snd, 2);

        // Per-chip cache: chip 1 then chip 0 with same register
        push(1, 8'h30, 8'h0F);
        wait_idle(400);
        sa = n_addr;
        push(0, 8'h30, 8'h0F);
        wait_idle(400);
        check("chip_cache_addr", n_addr - sa, 1);

        // Hold valid until full; nine entries accepted
        sd = n_data;
        valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chip  = 2'($urandom_range(0, 3));
            reg_a = 8'($urandom_range(0, 1) ? 8'h60 : 8'h61);
            data  = 8'($urandom);
            tick();
        end
        check("fill_ready", ready, 0);
        valid = 1'b0;
        wait_idle(1500);
        check("fill_writes", n_data - sd, 9);

        // Flush during the first address gap
        sd = n_data;
        push(0, 8'h40, 8'h01);
        push(1, 8'h41, 8'h02);
        push(0, 8'h42, 8'h03);
        push(1, 8'h43, 8'h04);
        wait_wr(1'b0, 1'b0, 1'b0);
        wait_wr(1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_level", level, 0);
        wait_idle(400);
        check("flush_writes", n_data - sd, 1);

        // Reset during the data strobe; cache must be invalidated
        push(0, 8'h50, 8'h66);
        wait_wr(1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        check("rst_wr_n", wr_n, 1);
        check("rst_cs_n", cs_n, 3);
        check("rst_d", d, 0);
        rst = 1'b0;
        tick();
        sa = n_addr;
        push(0, 8'h50, 8'h77);
        wait_idle(400);
        check("rst_cache_addr", n_addr - sa, 1);

        // Randomized bursts with occasional flush
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) begin
                valid = 1'($urandom_range(0, 1));
                chip  = 2'($urandom_range(0, 3));
                reg_a = 8'(8'h10 + 8'h10 * $urandom_range(0, 2));
                data  = 8'($urandom);
                flush = ($urandom_range(0, 15) == 0);
                tick();
            end
            valid = 1'b0;
            flush = 1'b0;
            wait_idle(1500);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
